// File: rtl/skew_deskew_array_pkg.sv
// Shared mode encoding and lane-delay helper for the skew/deskew array.
package skew_deskew_array_pkg;

  localparam logic MODE_SKEW   = 1'b0;
  localparam logic MODE_DESKEW = 1'b1;

  // Cycles of extra delay for a lane: staircase up in skew, staircase down in deskew.
  function automatic int unsigned lane_delay_of(input logic mode, input int unsigned lane,
                                                input int unsigned rows);
    return (mode == MODE_SKEW) ? lane : (rows - 1 - lane);
  endfunction

endpackage

// File: rtl/skew_deskew_array_lane_delay.sv
// One lane: ROWS-1 physical stages plus an output register. An element enters at the stage
// chosen by tap and walks toward stage 0, so stages past the tap never hold live data.
module lane_delay #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TW         = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [TW-1:0]         tap,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  stage_busy
);
  localparam int DEPTH = ROWS - 1;

  logic [DEPTH-1:0]                 r_vld;
  logic [DEPTH-1:0]                 r_lst;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_dat;
  logic [DEPTH-1:0]                 w_vld_up;
  logic [DEPTH-1:0]                 w_lst_up;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_dat_up;
  logic                             w_head_vld;
  logic                             w_head_lst;
  logic [DATA_WIDTH-1:0]            w_head_dat;
  logic                             r_out_vld;
  logic                             r_out_lst;
  logic [DATA_WIDTH-1:0]            r_out_dat;

  // Value flowing down into stage k from stage k+1 (zero above the top stage).
  assign w_vld_up = r_vld >> 1;
  assign w_lst_up = r_lst >> 1;
  assign w_dat_up = r_dat >> DATA_WIDTH;

  assign w_head_vld = (tap == '0) ? in_valid : r_vld[0];
  assign w_head_lst = (tap == '0) ? in_last  : r_lst[0];
  assign w_head_dat = (tap == '0) ? in_data  : r_dat[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= '0;
      r_lst     <= '0;
      r_dat     <= '0;
      r_out_vld <= 1'b0;
      r_out_lst <= 1'b0;
      r_out_dat <= '0;
    end else if (enable) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (tap == TW'(k + 1)) begin
          r_vld[k] <= in_valid;
          r_lst[k] <= in_last;
          r_dat[k] <= in_data;
        end else begin
          r_vld[k] <= w_vld_up[k];
          r_lst[k] <= w_lst_up[k];
          r_dat[k] <= w_dat_up[k];
        end
      end
      r_out_vld <= w_head_vld;
      r_out_lst <= w_head_vld & w_head_lst;
      r_out_dat <= w_head_vld ? w_head_dat : '0;
    end
  end

  assign out_valid  = r_out_vld;
  assign out_last   = r_out_lst;
  assign out_data   = r_out_dat;
  assign stage_busy = |r_vld;

endmodule

// File: rtl/skew_deskew_array.sv
// Per-lane staircase delay (skew) or its inverse (deskew) over ROWS lanes.
// Mode is latched only while the stages are empty, so all in-flight vectors share one delay profile.
module skew_deskew_array
  import skew_deskew_array_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       mode,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  output logic [ROWS-1:0]            out_valid,
  output logic [ROWS*DATA_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic                       busy
);
  localparam int TW = $clog2(ROWS);

  logic            r_mode_q;
  logic            w_busy;
  logic            w_mode_eff;
  logic [ROWS-1:0] w_stage_busy;
  logic [ROWS-1:0] w_lane_last;

  assign w_busy     = |w_stage_busy;
  assign w_mode_eff = w_busy ? r_mode_q : mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= MODE_SKEW;
    end else if (enable && !w_busy) begin
      r_mode_q <= mode;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_lane
      logic [TW-1:0]         w_tap;
      logic                  w_in_last;
      logic [DATA_WIDTH-1:0] w_in_data;

      assign w_tap     = TW'(lane_delay_of(w_mode_eff, gi, ROWS));
      // Only the longest lane carries the tile marker so it emerges with the last element.
      assign w_in_last = in_valid & in_last & (w_tap == TW'(ROWS - 1));
      assign w_in_data = in_valid ? in_data[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH] : '0;

      lane_delay #(
        .ROWS       (ROWS),
        .DATA_WIDTH (DATA_WIDTH),
        .TW         (TW)
      ) u_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .tap        (w_tap),
        .in_valid   (in_valid),
        .in_last    (w_in_last),
        .in_data    (w_in_data),
        .out_valid  (out_valid[gi]),
        .out_last   (w_lane_last[gi]),
        .out_data   (out_data[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH]),
        .stage_busy (w_stage_busy[gi])
      );
    end
  endgenerate

  assign out_last = |(w_lane_last & out_valid);
  assign busy     = w_busy;

endmodule

// File: tb/tb_skew_deskew_array.sv
// Scoreboard bench: the driver queues per-lane expectations, the monitor retires them each enabled cycle.
`timescale 1ns/1ps
module tb_skew_deskew_array;
  import skew_deskew_array_pkg::*;

  localparam int R = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [R*W-1:0] in_data = '0;
  logic [R-1:0]   out_valid, out_valid_b;
  logic [R*W-1:0] out_data, out_data_b;
  logic           out_last, out_last_b, busy, busy_b;

  always #5 clk = ~clk;

  skew_deskew_array #(.ROWS(R), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  // Second instance undoes the skew of the first.
  skew_deskew_array #(.ROWS(R), .DATA_WIDTH(W)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(MODE_DESKEW),
    .in_valid(|out_valid), .in_last(out_last), .in_data(out_data),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned lane;
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t        sb[$];
  exp_t        keep[$];
  int unsigned ecyc = 0;
  int unsigned last_ecyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [R-1:0]   prev_v = '0;
  logic [R*W-1:0] prev_d = '0;
  logic           prev_l = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, ecyc, act, exp);
    end
  endtask

  always @(posedge clk) if (rst_n && enable) ecyc <= ecyc + 1;

  always @(negedge clk) begin : monitor
    logic [R-1:0]   ev;
    logic [R*W-1:0] ed;
    logic           el;
    if (ecyc != last_ecyc) begin
      ev = '0; ed = '0; el = 1'b0;
      keep.delete();
      foreach (sb[k]) begin
        if (sb[k].cyc == ecyc) begin
          ev[sb[k].lane] = 1'b1;
          ed[sb[k].lane*W +: W] = sb[k].data;
          el = el | sb[k].last;
        end else begin
          keep.push_back(sb[k]);
        end
      end
      sb = keep;
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_data", out_data, ed);
      chk("out_last", 32'(out_last), 32'(el));
    end else begin
      chk("hold_valid", 32'(out_valid), 32'(prev_v));
      chk("hold_data", out_data, prev_d);
      chk("hold_last", 32'(out_last), 32'(prev_l));
    end
    prev_v = out_valid; prev_d = out_data; prev_l = out_last;
    last_ecyc = ecyc;
  end

  // dsk is the hand-chosen delay profile the vector must see (not derived from the DUT).
  task automatic drive(input logic v, input logic l, input logic [R*W-1:0] d,
                       input logic m, input logic en, input logic dsk);
    exp_t e;
    int   dl;
    @(negedge clk);
    in_valid = v; in_last = l; in_data = d; mode = m; enable = en;
    if (v && en) begin
      $display("tx cyc=%0d data=%h last=%b mode=%b profile=%s", ecyc, d, l, m, dsk ? "deskew" : "skew");
      for (int i = 0; i < R; i++) begin
        dl     = dsk ? (R - 1 - i) : i;
        e.cyc  = ecyc + 1 + dl;
        e.lane = i;
        e.data = d[i*W +: W];
        e.last = l && (dl == R - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input logic m);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'hdeadbeef, m, 1'b1, 1'b0);
  endtask

  int unsigned ni;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // Single skewed vector {3,2,1,0} with tile end.
    drive(1'b1, 1'b1, 32'h03020100, MODE_SKEW, 1'b1, 1'b0);
    idle(10, MODE_SKEW);

    // Round trip through the deskew instance: lanes realign after 5 cycles, tile end after 8.
    drive(1'b1, 1'b1, 32'h03020100, MODE_SKEW, 1'b1, 1'b0);
    ni = ecyc;
    for (int t = 1; t <= 10; t++) begin
      drive(1'b0, 1'b0, '0, MODE_SKEW, 1'b1, 1'b0);
      chk("rt_cycle", 32'(ecyc - ni), 32'(t));
      chk("rt_aligned", 32'(out_valid_b == 4'hF), 32'(t == 5));
      if (t == 5) chk("rt_data", out_data_b, 32'h03020100);
      if (t == 8) chk("rt_last", 32'(out_last_b), 1);
    end
    idle(6, MODE_SKEW);

    // Five vectors with a three-cycle stall in the middle; stalled inputs must be ignored.
    drive(1'b1, 1'b0, 32'h14131211, MODE_SKEW, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h24232221, MODE_SKEW, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'hbadbadba, MODE_SKEW, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'hbadbadba, MODE_DESKEW, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'hbadbadba, MODE_SKEW, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h34333231, MODE_SKEW, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h44434241, MODE_SKEW, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h54535251, MODE_SKEW, 1'b1, 1'b0);
    idle(10, MODE_SKEW);

    // Mode lock: mode=1 while busy keeps skew; first vector after busy falls is deskewed.
    drive(1'b1, 1'b0, 32'h44332211, MODE_SKEW, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h88776655, MODE_DESKEW, 1'b1, 1'b0);
    chk("busy_lock", 32'(busy), 1);
    idle(3, MODE_DESKEW);
    drive(1'b1, 1'b1, 32'hccbbaa99, MODE_DESKEW, 1'b1, 1'b1);
    chk("busy_idle_edge", 32'(busy), 0);
    idle(10, MODE_SKEW);

    // Reset pulse between edges with three vectors in flight.
    drive(1'b1, 1'b0, 32'h61626364, MODE_SKEW, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h71727374, MODE_SKEW, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h81828384, MODE_SKEW, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, MODE_SKEW, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(out_valid), 0);
    chk("rstmid_data", out_data, 0);
    chk("rstmid_last", 32'(out_last), 0);
    chk("rstmid_busy", 32'(busy), 0);
    sb.delete();
    #1 rst_n = 1'b1;
    idle(8, MODE_SKEW);

    // Alternating valid/idle slots; idle slots carry junk data that must never surface.
    drive(1'b1, 1'b0, 32'h0a0b0c0d, MODE_SKEW, 1'b1, 1'b0);
    idle(1, MODE_SKEW);
    drive(1'b1, 1'b0, 32'h1a1b1c1d, MODE_SKEW, 1'b1, 1'b0);
    idle(1, MODE_SKEW);
    drive(1'b1, 1'b1, 32'h2a2b2c2d, MODE_SKEW, 1'b1, 1'b0);
    idle(10, MODE_SKEW);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
